// File: rtl/univ_shift_reg_n_pkg.sv
// Shared opcode and FSM state encodings for the universal shifter and the sequencer that drives it.
package univ_shift_reg_n_pkg;

   typedef enum logic [2:0] {
      OP_NOP  = 3'd0,
      OP_LOAD = 3'd1,
      OP_SHL  = 3'd2,
      OP_SHR  = 3'd3,
      OP_ROL  = 3'd4,
      OP_ROR  = 3'd5,
      OP_ASR  = 3'd6,
      OP_CLR  = 3'd7
   } op_e;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_e;

   // Ops that run one bit per clock under the FSM.
   function automatic logic is_shift_op(op_e op);
      return (op >= OP_SHL) && (op <= OP_ASR);
   endfunction

endpackage

// File: rtl/univ_shift_reg_n_shift_step.sv
// One-bit step of a shift/rotate op; purely combinational, no latency, no flow control.
module univ_shift_reg_n_shift_step
   import univ_shift_reg_n_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  op_e              op,
   input  logic [WIDTH-1:0] p,
   input  logic             sin_left,
   input  logic             sin_right,
   output logic [WIDTH-1:0] next_p
);

   always_comb begin
      next_p = p;
      case (op)
         OP_SHL:  next_p = {p[WIDTH-2:0], sin_left};
         OP_SHR:  next_p = {sin_right, p[WIDTH-1:1]};
         OP_ROL:  next_p = {p[WIDTH-2:0], p[WIDTH-1]};
         OP_ROR:  next_p = {p[0], p[WIDTH-1:1]};
         OP_ASR:  next_p = {p[WIDTH-1], p[WIDTH-1:1]};
         default: next_p = p;
      endcase
   end

endmodule

// File: rtl/univ_shift_reg_n.sv
// Universal shift register: single-edge load/clear/NOP, N-bit shifts one bit per clock (N'+1 edges).
// Commands are accepted only in IDLE (cmd_ready); cmd_valid while busy is dropped, not queued.
module univ_shift_reg_n
   import univ_shift_reg_n_pkg::*;
#(
   parameter  int WIDTH = 8,
   localparam int AMT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [AMT_W-1:0] cmd_amt,
   input  logic             abort,
   input  logic [WIDTH-1:0] p_in,
   input  logic             sin_left,
   input  logic             sin_right,
   output logic [WIDTH-1:0] p_out,
   output logic             sout_left,
   output logic             sout_right,
   output logic             busy,
   output logic             done
);

   localparam logic [AMT_W-1:0] AMT_MAX = AMT_W'(WIDTH);
   localparam logic [AMT_W-1:0] AMT_ONE = AMT_W'(1);

   state_e           state_q, state_d;
   op_e              op_q, op_d;
   logic [AMT_W-1:0] count_q, count_d;
   logic [WIDTH-1:0] p_q, p_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] step_p;
   op_e              cmd_op_e;

   assign cmd_op_e = op_e'(cmd_op);

   univ_shift_reg_n_shift_step #(.WIDTH(WIDTH)) u_step (
      .op        (op_q),
      .p         (p_q),
      .sin_left  (sin_left),
      .sin_right (sin_right),
      .next_p    (step_p)
   );

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      count_d = count_q;
      p_d     = p_q;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               if (is_shift_op(cmd_op_e) && (cmd_amt != '0)) begin
                  state_d = ST_SHIFT;
                  op_d    = cmd_op_e;
                  count_d = (cmd_amt > AMT_MAX) ? AMT_MAX : cmd_amt;
               end else begin
                  done_d = 1'b1;
                  if (cmd_op_e == OP_LOAD) begin
                     p_d = p_in;
                  end else if (cmd_op_e == OP_CLR) begin
                     p_d = '0;
                  end
               end
            end
         end
         ST_SHIFT: begin
            // Abort leaves the partial result in place and skips this edge's step.
            if (abort) begin
               state_d = ST_IDLE;
               count_d = '0;
            end else begin
               p_d     = step_p;
               count_d = count_q - AMT_ONE;
               if (count_q == AMT_ONE) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         op_q    <= OP_NOP;
         count_q <= '0;
         p_q     <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         count_q <= count_d;
         p_q     <= p_d;
         done_q  <= done_d;
      end
   end

   assign p_out      = p_q;
   assign sout_left  = p_q[WIDTH-1];
   assign sout_right = p_q[0];
   assign cmd_ready  = (state_q == ST_IDLE);
   assign busy       = (state_q == ST_SHIFT);
   assign done       = done_q;

endmodule

// File: tb/tb_univ_shift_reg_n.sv
// Bench for univ_shift_reg_n: directed scenarios plus random traffic against a behavioural model.
module tb_univ_shift_reg_n;

   localparam int W     = 8;
   localparam int AMT_W = $clog2(W + 1);

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             cmd_valid = 1'b0;
   logic             cmd_ready;
   logic [2:0]       cmd_op = 3'd0;
   logic [AMT_W-1:0] cmd_amt = '0;
   logic             abort = 1'b0;
   logic [W-1:0]     p_in = '0;
   logic             sin_left = 1'b0;
   logic             sin_right = 1'b0;
   logic [W-1:0]     p_out;
   logic             sout_left, sout_right, busy, done;

   univ_shift_reg_n #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_op     (cmd_op),
      .cmd_amt    (cmd_amt),
      .abort      (abort),
      .p_in       (p_in),
      .sin_left   (sin_left),
      .sin_right  (sin_right),
      .p_out      (p_out),
      .sout_left  (sout_left),
      .sout_right (sout_right),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int busy_cycles = 0;
   int done_cnt = 0;

   // Model: register value, steps still owed, pending op, done pulse.
   logic [W-1:0] m_p = '0;
   int           m_rem = 0;
   int           m_op = 0;
   bit           m_done = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] step1(input int op, input logic [W-1:0] v,
                                          input bit sl, input bit sr);
      int unsigned u, r, msb;
      u   = int'(v);
      msb = 32'd1 << (W - 1);
      case (op)
         2:       r = (u << 1) | int'(sl);
         3:       r = (u >> 1) | (sr ? msb : 0);
         4:       r = (u << 1) | (u >> (W - 1));
         5:       r = (u >> 1) | (((u & 1) != 0) ? msb : 0);
         6:       r = (u >> 1) | (u & msb);
         default: r = u;
      endcase
      return W'(r);
   endfunction

   task automatic check_outputs();
      chk("p_out", 32'(p_out), 32'(m_p));
      chk("busy", 32'(busy), 32'(m_rem != 0));
      chk("cmd_ready", 32'(cmd_ready), 32'(m_rem == 0));
      chk("done", 32'(done), 32'(m_done));
      chk("sout_left", 32'(sout_left), 32'(m_p[W-1]));
      chk("sout_right", 32'(sout_right), 32'(m_p[0]));
   endtask

   // Predict from the inputs held across the coming edge, then compare just after it.
   task automatic cycle();
      logic [W-1:0] np;
      int           nrem, nop, n;
      bit           nd;
      np = m_p; nrem = m_rem; nop = m_op; nd = 1'b0;
      if (m_rem == 0) begin
         if (cmd_valid) begin
            case (int'(cmd_op))
               0: nd = 1'b1;
               1: begin np = p_in; nd = 1'b1; end
               7: begin np = '0;   nd = 1'b1; end
               default: begin
                  n = (int'(cmd_amt) > W) ? W : int'(cmd_amt);
                  if (n == 0) nd = 1'b1;
                  else begin nrem = n; nop = int'(cmd_op); end
               end
            endcase
         end
      end else if (abort) begin
         nrem = 0;
      end else begin
         np   = step1(m_op, m_p, sin_left, sin_right);
         nrem = m_rem - 1;
         nd   = (nrem == 0);
      end
      @(posedge clk);
      #1;
      m_p = np; m_rem = nrem; m_op = nop; m_done = nd;
      check_outputs();
      if (busy) busy_cycles++;
      if (done) done_cnt++;
   endtask

   task automatic issue(input int op, input int amt, input logic [W-1:0] d);
      cmd_valid = 1'b1;
      cmd_op    = 3'(op);
      cmd_amt   = AMT_W'(amt);
      p_in      = d;
      cycle();
      cmd_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int i;
      i = 0;
      while (busy && i < 40) begin
         cycle();
         i++;
      end
      chk("idle_timeout", 32'(busy), 32'd0);
   endtask

   initial begin
      #2;
      chk("rst_p_out", 32'(p_out), 32'h00);
      chk("rst_ready", 32'(cmd_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_sout", 32'({sout_left, sout_right}), 32'd0);
      #10 rst = 1'b0;

      // Load with a single-cycle done and no busy.
      busy_cycles = 0; done_cnt = 0;
      issue(1, 0, 8'hA5);
      chk("load_val", 32'(p_out), 32'hA5);
      cycle();
      chk("load_done_cnt", 32'(done_cnt), 32'd1);
      chk("load_busy_cnt", 32'(busy_cycles), 32'd0);

      // SHL by 3 with serial ones.
      busy_cycles = 0; done_cnt = 0; sin_left = 1'b1;
      issue(2, 3, 8'h00);
      wait_idle();
      chk("shl_val", 32'(p_out), 32'h2F);
      chk("shl_busy_cnt", 32'(busy_cycles), 32'd3);
      chk("shl_done_cnt", 32'(done_cnt), 32'd1);
      sin_left = 1'b0;

      issue(1, 0, 8'hA5);
      issue(5, 4, 8'h00);
      wait_idle();
      chk("ror_val", 32'(p_out), 32'h5A);
      issue(1, 0, 8'h85);
      issue(6, 2, 8'h00);
      wait_idle();
      chk("asr_val", 32'(p_out), 32'hE1);

      // Oversized amount clamps to W steps.
      issue(1, 0, 8'hFF);
      sin_right = 1'b0; busy_cycles = 0;
      issue(3, 12, 8'h00);
      wait_idle();
      chk("shr_clamp_val", 32'(p_out), 32'h00);
      chk("shr_clamp_busy", 32'(busy_cycles), 32'd8);

      // Abort after two rotate steps; a command offered mid-shift is dropped.
      issue(1, 0, 8'h01);
      done_cnt = 0;
      issue(4, 5, 8'h00);
      cmd_valid = 1'b1; cmd_op = 3'd1; p_in = 8'hFF;
      cycle();
      cmd_valid = 1'b0;
      cycle();
      abort = 1'b1;
      cycle();
      abort = 1'b0;
      chk("abort_val", 32'(p_out), 32'h04);
      chk("abort_done_cnt", 32'(done_cnt), 32'd0);
      chk("abort_ready", 32'(cmd_ready), 32'd1);
      abort = 1'b1;
      cycle();
      abort = 1'b0;
      chk("abort_idle_noop", 32'(p_out), 32'h04);

      // Asynchronous reset in the middle of a shift.
      issue(1, 0, 8'hC3);
      done_cnt = 0;
      issue(2, 5, 8'h00);
      cycle();
      #3 rst = 1'b1;
      #1;
      m_p = '0; m_rem = 0; m_done = 1'b0;
      chk("arst_p_out", 32'(p_out), 32'h00);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_ready", 32'(cmd_ready), 32'd1);
      chk("arst_sout", 32'({sout_left, sout_right}), 32'd0);
      @(posedge clk);
      #1;
      check_outputs();
      rst = 1'b0;
      chk("arst_done_cnt", 32'(done_cnt), 32'd0);
      issue(1, 0, 8'h3C);
      chk("post_rst_load", 32'(p_out), 32'h3C);

      // Random traffic.
      for (int i = 0; i < 600; i++) begin
         cmd_valid = ($urandom_range(0, 1) == 1);
         cmd_op    = 3'($urandom_range(0, 7));
         cmd_amt   = AMT_W'($urandom_range(0, (1 << AMT_W) - 1));
         abort     = ($urandom_range(0, 9) == 0);
         p_in      = W'($urandom);
         sin_left  = 1'($urandom);
         sin_right = 1'($urandom);
         cycle();
      end
      cmd_valid = 1'b0;
      abort     = 1'b0;

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
